// File: rtl/truth_table_capture_pkg.sv
// Shared types and constants for the truth-table capture block: FSM encoding,
// settle-counter width and a helper sizing the analyzer's variable index.
package truth_table_capture_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DRIVE   = 3'd1,
      ST_SAMPLE  = 3'd2,
      ST_ANALYZE = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   // SETTLE is limited to 1..15, so four bits always hold SETTLE-1.
   localparam int SETTLE_W = 4;

   function automatic int var_width(input int n_vars);
      return (n_vars > 1) ? $clog2(n_vars) : 1;
   endfunction

endpackage

// File: rtl/truth_table_capture_analyzer.sv
// Combinational analysis of one output's minterm mask: dependence on a selected
// variable plus all-ones / all-zeros detection.
module truth_table_capture_analyzer #(
   parameter int N_VARS = 3,
   parameter int VAR_W  = 2
) (
   input  logic [(1<<N_VARS)-1:0] i_mask,
   input  logic [VAR_W-1:0]       i_var,
   output logic                   o_dep,
   output logic                   o_all1,
   output logic                   o_all0
);

   localparam int TT_BITS = 1 << N_VARS;

   // A variable matters iff flipping it changes the output for some minterm.
   always_comb begin
      logic [N_VARS-1:0] w_partner;
      w_partner = '0;
      o_dep     = 1'b0;
      for (int j = 0; j < TT_BITS; j++) begin
         w_partner = N_VARS'(j) ^ (N_VARS'(1) << i_var);
         o_dep     = o_dep | (i_mask[j] ^ i_mask[w_partner]);
      end
   end

   assign o_all1 = &i_mask;
   assign o_all0 = ~|i_mask;

endmodule

// File: rtl/truth_table_capture.sv
// Sweeps every input combination into a function-under-test, captures its outputs
// into per-output truth tables and derives constant flags and variable dependence.
module truth_table_capture
   import truth_table_capture_pkg::*;
#(
   parameter int N_VARS = 3,
   parameter int N_OUT  = 2,
   parameter int SETTLE = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   output logic [N_VARS-1:0]              stim,
   input  logic [N_OUT-1:0]               resp,
   output logic                           busy,
   output logic                           done,
   output logic [N_OUT*(1<<N_VARS)-1:0]   tt,
   output logic [N_OUT-1:0]               const1,
   output logic [N_OUT-1:0]               const0,
   output logic [N_OUT*N_VARS-1:0]        depends,
   output state_t                         o_dbg_state
);

   localparam int TT_BITS = 1 << N_VARS;
   localparam int VAR_W   = var_width(N_VARS);

   state_t                       r_state;
   logic [N_VARS-1:0]            r_idx;
   logic [SETTLE_W-1:0]          r_settle;
   logic [VAR_W-1:0]             r_var;
   logic [N_VARS-1:0]            r_stim;
   logic                         r_busy;
   logic                         r_done;
   logic [N_OUT*TT_BITS-1:0]     r_tt;
   logic [N_OUT-1:0]             r_const1;
   logic [N_OUT-1:0]             r_const0;
   logic [N_OUT*N_VARS-1:0]      r_depends;

   logic [N_OUT-1:0]             w_dep;
   logic [N_OUT-1:0]             w_all1;
   logic [N_OUT-1:0]             w_all0;

   for (genvar o = 0; o < N_OUT; o++) begin : g_an
      truth_table_capture_analyzer #(
         .N_VARS (N_VARS),
         .VAR_W  (VAR_W)
      ) u_an (
         .i_mask (r_tt[o*TT_BITS +: TT_BITS]),
         .i_var  (r_var),
         .o_dep  (w_dep[o]),
         .o_all1 (w_all1[o]),
         .o_all0 (w_all0[o])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_idx     <= '0;
         r_settle  <= '0;
         r_var     <= '0;
         r_stim    <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_tt      <= '0;
         r_const1  <= '0;
         r_const0  <= '0;
         r_depends <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state   <= ST_DRIVE;
                  r_idx     <= '0;
                  r_settle  <= '0;
                  r_stim    <= '0;
                  r_tt      <= '0;
                  r_const1  <= '0;
                  r_const0  <= '0;
                  r_depends <= '0;
                  r_busy    <= 1'b1;
               end
            end
            ST_DRIVE: begin
               if (r_settle == SETTLE_W'(SETTLE - 1)) begin
                  r_state  <= ST_SAMPLE;
                  r_settle <= '0;
               end else begin
                  r_settle <= r_settle + 1'b1;
               end
            end
            ST_SAMPLE: begin
               for (int o = 0; o < N_OUT; o++) begin
                  r_tt[o*TT_BITS + int'(r_idx)] <= resp[o];
               end
               if (r_idx == {N_VARS{1'b1}}) begin
                  r_state <= ST_ANALYZE;
                  r_var   <= '0;
                  r_stim  <= '0;
               end else begin
                  r_state <= ST_DRIVE;
                  r_idx   <= r_idx + 1'b1;
                  r_stim  <= r_idx + 1'b1;
               end
            end
            ST_ANALYZE: begin
               // One variable per cycle; constant flags only need one look.
               for (int o = 0; o < N_OUT; o++) begin
                  r_depends[o*N_VARS + int'(r_var)] <= w_dep[o];
               end
               if (r_var == '0) begin
                  r_const1 <= w_all1;
                  r_const0 <= w_all0;
               end
               if (r_var == VAR_W'(N_VARS - 1)) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_var <= r_var + 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign stim        = r_stim;
   assign busy        = r_busy;
   assign done        = r_done;
   assign tt          = r_tt;
   assign const1      = r_const1;
   assign const0      = r_const0;
   assign depends     = r_depends;
   assign o_dbg_state = r_state;

endmodule
